// File: rtl/sm_trace_buffer.sv
// Execution trace recorder: samples {instr, pc} per retired cycle into a circular RAM
// and stops on a cycle limit, PC match or masked instruction match plus post-trigger depth.
module sm_trace_buffer #(
  parameter int DEPTH   = 64,
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32,
  parameter int CNT_W   = 32,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [PC_W-1:0]         pc,
  input  logic [INSTR_W-1:0]      instr,
  input  logic                    arm,
  input  logic [1:0]              cfg_mode,
  input  logic [31:0]             cfg_match,
  input  logic [31:0]             cfg_mask,
  input  logic [CNT_W-1:0]        cfg_count,
  input  logic [AW-1:0]           rd_addr,
  output logic [INSTR_W+PC_W-1:0] rd_data,
  output logic                    rd_valid,
  output logic [1:0]              state,
  output logic                    triggered,
  output logic                    done,
  output logic                    stop_req,
  output logic [AW:0]             fill,
  output logic [CNT_W-1:0]        cycle_cnt
);

  typedef enum logic [1:0] {S_IDLE = 2'b00, S_ARMED = 2'b01, S_POST = 2'b10, S_DONE = 2'b11} state_t;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  state_t                    r_state;
  logic [AW-1:0]             r_wr_ptr;
  logic [AW:0]               r_fill;
  logic [CNT_W-1:0]          r_cycle_cnt;
  logic [CNT_W-1:0]          r_post_cnt;
  logic [1:0]                r_mode;
  logic [31:0]               r_match;
  logic [31:0]               r_mask;
  logic [CNT_W-1:0]          r_count;
  logic                      r_triggered;
  logic                      r_stop_req;
  logic [INSTR_W+PC_W-1:0]   r_rd_data;
  logic                      r_rd_valid;
  logic [INSTR_W+PC_W-1:0]   r_mem [DEPTH];

  logic                      w_wr;
  logic                      w_hit;
  logic [CNT_W-1:0]          w_cyc_next;
  logic [AW-1:0]             w_oldest;
  logic [AW-1:0]             w_phys;
  logic                      w_rd_hit;

  // Mode 01 with a zero limit finishes without ever taking a sample
  assign w_wr = en && !arm &&
                ((r_state == S_ARMED && !(r_mode == 2'b01 && r_count == '0)) ||
                 r_state == S_POST);

  assign w_hit = (r_mode == 2'b10) ? (pc == r_match[PC_W-1:0])
                                   : (((instr ^ r_match[INSTR_W-1:0]) & r_mask[INSTR_W-1:0]) == '0);

  assign w_cyc_next = (&r_cycle_cnt) ? r_cycle_cnt : r_cycle_cnt + 1'b1;

  // Once the ring has wrapped, the oldest entry sits at the write pointer
  assign w_oldest = (r_fill == FULL) ? r_wr_ptr : '0;
  assign w_phys   = w_oldest + rd_addr;
  assign w_rd_hit = ({1'b0, rd_addr} < r_fill);

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= {instr, pc};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_fill      <= '0;
      r_cycle_cnt <= '0;
      r_post_cnt  <= '0;
      r_mode      <= '0;
      r_match     <= '0;
      r_mask      <= '0;
      r_count     <= '0;
      r_triggered <= 1'b0;
      r_stop_req  <= 1'b0;
      r_rd_data   <= '0;
      r_rd_valid  <= 1'b0;
    end else begin
      r_stop_req <= 1'b0;
      r_rd_valid <= w_rd_hit;
      r_rd_data  <= w_rd_hit ? r_mem[w_phys] : '0;
      if (arm) begin
        r_state     <= S_ARMED;
        r_wr_ptr    <= '0;
        r_fill      <= '0;
        r_cycle_cnt <= '0;
        r_post_cnt  <= '0;
        r_triggered <= 1'b0;
        r_mode      <= cfg_mode;
        r_match     <= cfg_match;
        r_mask      <= cfg_mask;
        r_count     <= cfg_count;
      end else begin
        if (w_wr) begin
          r_wr_ptr    <= r_wr_ptr + 1'b1;
          r_fill      <= (r_fill == FULL) ? r_fill : r_fill + 1'b1;
          r_cycle_cnt <= w_cyc_next;
        end
        case (r_state)
          S_ARMED: begin
            if (r_mode == 2'b01) begin
              if (r_count == '0 || (en && w_cyc_next == r_count)) begin
                r_state    <= S_DONE;
                r_stop_req <= 1'b1;
              end
            end else if (r_mode != 2'b00 && en && w_hit) begin
              r_triggered <= 1'b1;
              r_post_cnt  <= r_count;
              if (r_count == '0) begin
                r_state    <= S_DONE;
                r_stop_req <= 1'b1;
              end else begin
                r_state <= S_POST;
              end
            end
          end
          S_POST: begin
            if (en) begin
              r_post_cnt <= r_post_cnt - 1'b1;
              if (r_post_cnt == CNT_W'(1)) begin
                r_state    <= S_DONE;
                r_stop_req <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign rd_data   = r_rd_data;
  assign rd_valid  = r_rd_valid;
  assign state     = r_state;
  assign triggered = r_triggered;
  assign done      = (r_state == S_DONE);
  assign stop_req  = r_stop_req;
  assign fill      = r_fill;
  assign cycle_cnt = r_cycle_cnt;

endmodule

// File: tb/tb_sm_trace_buffer.sv
// Scenario bench for sm_trace_buffer (DEPTH=8): a model queue of expected ring contents
// feeds a read scoreboard that is popped as each registered read result appears.
module tb_sm_trace_buffer;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        arm;
  logic [1:0]  cfg_mode;
  logic [31:0] cfg_match;
  logic [31:0] cfg_mask;
  logic [31:0] cfg_count;
  logic [2:0]  rd_addr;
  logic [63:0] rd_data;
  logic        rd_valid;
  logic [1:0]  state;
  logic        triggered;
  logic        done;
  logic        stop_req;
  logic [3:0]  fill;
  logic [31:0] cycle_cnt;

  int checks = 0;
  int failures = 0;
  logic [63:0] model_q[$];
  logic [63:0] sb_q[$];

  sm_trace_buffer #(.DEPTH(DEPTH), .PC_W(32), .INSTR_W(32), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .en(en), .pc(pc), .instr(instr), .arm(arm),
    .cfg_mode(cfg_mode), .cfg_match(cfg_match), .cfg_mask(cfg_mask), .cfg_count(cfg_count),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid), .state(state),
    .triggered(triggered), .done(done), .stop_req(stop_req), .fill(fill), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_write(input logic [31:0] p, input logic [31:0] i);
    model_q.push_back({i, p});
    if (model_q.size() > DEPTH) void'(model_q.pop_front());
  endtask

  task automatic do_arm(input logic [1:0] m, input logic [31:0] mt, input logic [31:0] mk,
                        input logic [31:0] c);
    cfg_mode = m; cfg_match = mt; cfg_mask = mk; cfg_count = c;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    model_q.delete();
    checks++;
    if (state !== 2'b01 || fill !== 4'd0) begin
      failures++;
      $display("FAIL arm_state: state=%0d fill=%0d, want state=1 fill=0", state, fill);
    end
  endtask

  task automatic sample(input int k, input logic [31:0] i);
    pc = 32'(4 * k); instr = i; en = 1'b1;
    tick();
    en = 1'b0;
  endtask

  task automatic read_back(input string name);
    logic [63:0] exp_d;
    for (int a = 0; a < model_q.size(); a++) begin
      rd_addr = 3'(a);
      sb_q.push_back(model_q[a]);
      tick();
      exp_d = sb_q.pop_front();
      checks++;
      if (rd_data !== exp_d || rd_valid !== 1'b1) begin
        failures++;
        $display("FAIL %s_rd%0d: data=%h valid=%b, want data=%h valid=1", name, a, rd_data, rd_valid, exp_d);
      end
    end
    if (model_q.size() < DEPTH) begin
      rd_addr = 3'(model_q.size());
      tick();
      checks++;
      if (rd_data !== 64'd0 || rd_valid !== 1'b0) begin
        failures++;
        $display("FAIL %s_rd_invalid: data=%h valid=%b, want 0/0", name, rd_data, rd_valid);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 0; arm = 0; pc = 0; instr = 0;
    cfg_mode = 0; cfg_match = 0; cfg_mask = 0; cfg_count = 0; rd_addr = 0;
    #3;
    checks++;
    if (state !== 2'b00 || triggered !== 0 || done !== 0 || stop_req !== 0 ||
        fill !== 0 || cycle_cnt !== 0 || rd_valid !== 0 || rd_data !== 64'd0) begin
      failures++;
      $display("FAIL reset: state=%0d trig=%b done=%b stop=%b fill=%0d cyc=%0d rv=%b rd=%h, want all 0",
               state, triggered, done, stop_req, fill, cycle_cnt, rd_valid, rd_data);
    end
    tick(); tick();
    rst = 1'b0;
    sample(0, 32'h2000_0000);
    checks++;
    if (fill !== 0 || state !== 2'b00) begin
      failures++;
      $display("FAIL idle_ignore: fill=%0d state=%0d, want 0/0", fill, state);
    end
  endtask

  task automatic test_cycle_limit();
    int pulses = 0;
    do_arm(2'b01, 32'h0, 32'h0, 32'd5);
    cfg_count = 32'd2;
    for (int k = 0; k < 10; k++) begin
      sample(k, 32'h2000_0000 | 32'(k));
      if (k < 5) model_write(32'(4 * k), 32'h2000_0000 | 32'(k));
      if (stop_req === 1'b1) pulses++;
      if (k == 4) begin
        checks++;
        if (state !== 2'b11 || done !== 1'b1 || stop_req !== 1'b1) begin
          failures++;
          $display("FAIL limit_done: state=%0d done=%b stop=%b, want 3/1/1", state, done, stop_req);
        end
      end
    end
    checks++;
    if (pulses != 1 || fill !== 4'd5 || cycle_cnt !== 32'd5 || triggered !== 1'b0) begin
      failures++;
      $display("FAIL limit_counts: pulses=%0d fill=%0d cyc=%0d trig=%b, want 1/5/5/0",
               pulses, fill, cycle_cnt, triggered);
    end
    read_back("limit");
  endtask

  task automatic test_free_run();
    do_arm(2'b00, 32'h0, 32'h0, 32'd0);
    for (int k = 0; k < 20; k++) begin
      sample(k, 32'h2000_0000 | 32'(k));
      model_write(32'(4 * k), 32'h2000_0000 | 32'(k));
    end
    checks++;
    if (state !== 2'b01 || fill !== 4'd8 || cycle_cnt !== 32'd20 || stop_req !== 1'b0) begin
      failures++;
      $display("FAIL free_counts: state=%0d fill=%0d cyc=%0d stop=%b, want 1/8/20/0",
               state, fill, cycle_cnt, stop_req);
    end
    checks++;
    if (model_q[0][31:0] !== 32'h30 || model_q[7][31:0] !== 32'h4C) begin
      failures++;
      $display("FAIL free_model: oldest=%h newest=%h, want 30/4C", model_q[0][31:0], model_q[7][31:0]);
    end
    read_back("free1");
    read_back("free2");
  endtask

  task automatic test_pc_trigger();
    do_arm(2'b10, 32'h20, 32'h0, 32'd3);
    for (int k = 0; k < 16; k++) begin
      sample(k, 32'h2000_0000 | 32'(k));
      if (k <= 11) model_write(32'(4 * k), 32'h2000_0000 | 32'(k));
      if (k == 8) begin
        checks++;
        if (triggered !== 1'b1 || state !== 2'b10) begin
          failures++;
          $display("FAIL pc_trig: trig=%b state=%0d, want 1/2", triggered, state);
        end
      end
      if (k == 10) begin
        checks++;
        if (state !== 2'b10) begin
          failures++;
          $display("FAIL pc_post: state=%0d, want 2", state);
        end
      end
      if (k == 11) begin
        checks++;
        if (state !== 2'b11 || stop_req !== 1'b1) begin
          failures++;
          $display("FAIL pc_done: state=%0d stop=%b, want 3/1", state, stop_req);
        end
      end
    end
    checks++;
    if (fill !== 4'd8 || cycle_cnt !== 32'd12 || stop_req !== 1'b0 || done !== 1'b1) begin
      failures++;
      $display("FAIL pc_counts: fill=%0d cyc=%0d stop=%b done=%b, want 8/12/0/1",
               fill, cycle_cnt, stop_req, done);
    end
    read_back("pc");
  endtask

  task automatic test_instr_trigger();
    logic [31:0] iv;
    do_arm(2'b11, 32'h0800_0000, 32'hFC00_0000, 32'd0);
    for (int k = 0; k < 9; k++) begin
      iv = (k == 6) ? 32'h0800_0010 : (32'h2000_0000 | 32'(k));
      sample(k, iv);
      if (k <= 6) model_write(32'(4 * k), iv);
      if (k == 5) begin
        checks++;
        if (triggered !== 1'b0 || state !== 2'b01) begin
          failures++;
          $display("FAIL instr_early: trig=%b state=%0d, want 0/1", triggered, state);
        end
      end
      if (k == 6) begin
        checks++;
        if (triggered !== 1'b1 || state !== 2'b11 || stop_req !== 1'b1) begin
          failures++;
          $display("FAIL instr_trig: trig=%b state=%0d stop=%b, want 1/3/1", triggered, state, stop_req);
        end
      end
    end
    checks++;
    if (fill !== 4'd7 || cycle_cnt !== 32'd7) begin
      failures++;
      $display("FAIL instr_counts: fill=%0d cyc=%0d, want 7/7", fill, cycle_cnt);
    end
    read_back("instr");
  endtask

  task automatic test_arm_with_en();
    cfg_mode = 2'b00; cfg_count = 0;
    arm = 1'b1; en = 1'b1; pc = 32'h100; instr = 32'h2000_0000;
    tick();
    arm = 1'b0; en = 1'b0;
    model_q.delete();
    checks++;
    if (fill !== 4'd0 || cycle_cnt !== 32'd0 || state !== 2'b01 || done !== 1'b0) begin
      failures++;
      $display("FAIL arm_en: fill=%0d cyc=%0d state=%0d done=%b, want 0/0/1/0", fill, cycle_cnt, state, done);
    end
    read_back("arm_en");
  endtask

  task automatic test_reset_mid_post();
    do_arm(2'b10, 32'h20, 32'h0, 32'd3);
    for (int k = 0; k < 10; k++) sample(k, 32'h2000_0000 | 32'(k));
    rd_addr = 3'd0;
    tick();
    checks++;
    if (state !== 2'b10 || rd_valid !== 1'b1) begin
      failures++;
      $display("FAIL pre_rst: state=%0d rv=%b, want 2/1", state, rd_valid);
    end
    rst = 1'b1;
    #2;
    checks++;
    if (state !== 2'b00 || done !== 0 || stop_req !== 0 || fill !== 0 || rd_valid !== 0 ||
        triggered !== 0 || cycle_cnt !== 0) begin
      failures++;
      $display("FAIL async_rst: state=%0d done=%b stop=%b fill=%0d rv=%b trig=%b cyc=%0d, want all 0",
               state, done, stop_req, fill, rd_valid, triggered, cycle_cnt);
    end
    tick();
    rst = 1'b0;
    do_arm(2'b01, 32'h0, 32'h0, 32'd2);
    for (int k = 0; k < 4; k++) begin
      sample(k, 32'h2000_0000 | 32'(k));
      if (k < 2) model_write(32'(4 * k), 32'h2000_0000 | 32'(k));
    end
    checks++;
    if (state !== 2'b11 || fill !== 4'd2) begin
      failures++;
      $display("FAIL rearm: state=%0d fill=%0d, want 3/2", state, fill);
    end
    read_back("rearm");
  endtask

  initial begin
    test_reset();
    test_cycle_limit();
    test_free_run();
    test_pc_trigger();
    test_instr_trigger();
    test_arm_with_en();
    test_reset_mid_post();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
